wb_spr_bridge: RTL

WB_SPR_BRIDGE -- requirements
Module: wb_spr_bridge

---
 rtl/wb_spr_bridge_pkg.sv | 26 ++
 rtl/wb_spr_bridge_if.sv | 29 ++
 rtl/wb_spr_group_decode.sv | 27 ++
 rtl/wb_spr_bridge.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/wb_spr_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SPR bridge.
//   state_e          : bridge FSM states (also exported on the debug port)
//   SPR_GROUP_SHIFT  : bit position of the SPR group field in a Wishbone address
//   SPR_GROUP_*      : well-known SPR group numbers
//   spr_group()      : extracts the 5-bit group field from an address
package wb_spr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int SPR_GROUP_SHIFT = 11;
  localparam int SPR_GROUP_W     = 5;

  localparam logic [4:0] SPR_GROUP_PIC = 5'd9;
  localparam logic [4:0] SPR_GROUP_TT  = 5'd10;
  localparam logic [4:0] SPR_GROUP_FP  = 5'd11;

  function automatic logic [SPR_GROUP_W-1:0] spr_group(input logic [15:0] adr);
    return adr[SPR_GROUP_SHIFT +: SPR_GROUP_W];
  endfunction

endpackage

// File: rtl/wb_spr_bridge_if.sv
// Classic Wishbone bus bundle (no pipelining, no burst tags).
//   master modport : drives cyc/stb/we/adr/dat_w, receives dat_r/ack/err
//   slave modport  : the mirror image
// Handshake: a transfer is requested while cyc and stb are both high; the
// slave completes it by raising exactly one of ack or err for one cycle.
// The master holds its request stable until that cycle.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_spr_group_decode.sv
// Combinational SPR group decoder.
//   group     : 5-bit group field from the request address
//   group_ids : packed per-channel group numbers, channel k in slice k
//   hit       : some channel owns this group
//   sel       : one-hot channel select (all zero when no hit)
// When two channels carry the same ID the lowest-index one wins.
module wb_spr_group_decode #(
  parameter int N_GROUPS = 2
) (
  input  logic [4:0]            group,
  input  logic [N_GROUPS*5-1:0] group_ids,
  output logic                  hit,
  output logic [N_GROUPS-1:0]   sel
);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < N_GROUPS; k++) begin
      if (!hit && (group_ids[k*5 +: 5] == group)) begin
        hit    = 1'b1;
        sel[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_spr_bridge.sv
// Wishbone slave that forwards single accesses to one of N_GROUPS SPR
// channels selected by the address group field ADR[15:11].
//   clk, rstn   : clock, asynchronous active-low reset
//   s           : Wishbone slave port
//   spr_cs      : per-channel chip select, one-cycle pulse in ACCESS
//   spr_write   : write qualifier, valid while spr_cs is high
//   spr_addr    : latched request address
//   spr_dat_i   : latched write data
//   spr_dat_o   : flattened per-channel read data, channel k at [k*W +: W]
//   busy        : FSM is not idle
//   dbg_state   : current FSM state
// Flow: IDLE -> ACCESS -> [WAIT x WAIT_STATES] -> RESP -> IDLE for mapped
// groups, IDLE -> RESP -> IDLE for unmapped ones.
module wb_spr_bridge
  import wb_spr_bridge_pkg::*;
#(
  parameter int                    WB_ADDR_WIDTH   = 32,
  parameter int                    WB_DATA_WIDTH   = 32,
  parameter int                    N_GROUPS        = 2,
  parameter logic [N_GROUPS*5-1:0] GROUP_IDS       = {5'd10, 5'd9},
  parameter int                    WAIT_STATES     = 0,
  parameter int                    ERR_ON_UNMAPPED = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  wb_if.slave                               s,
  output logic [N_GROUPS-1:0]               spr_cs,
  output logic                              spr_write,
  output logic [WB_ADDR_WIDTH-1:0]          spr_addr,
  output logic [WB_DATA_WIDTH-1:0]          spr_dat_i,
  input  logic [N_GROUPS*WB_DATA_WIDTH-1:0] spr_dat_o,
  output logic                              busy,
  output state_e                            dbg_state
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic       HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic       ERR_EN    = (ERR_ON_UNMAPPED != 0);

  state_e                     state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                       we_q, we_d;
  logic                       hit_q, hit_d;
  logic [N_GROUPS-1:0]        sel_q, sel_d;
  logic [WB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [3:0]                 cnt_q, cnt_d;

  logic [4:0]                 group_w;
  logic                       dec_hit;
  logic [N_GROUPS-1:0]        dec_sel;
  logic [WB_DATA_WIDTH-1:0]   rd_mux;

  assign group_w = spr_group(s.adr[15:0]);

  wb_spr_group_decode #(
    .N_GROUPS (N_GROUPS)
  ) u_decode (
    .group     (group_w),
    .group_ids (GROUP_IDS),
    .hit       (dec_hit),
    .sel       (dec_sel)
  );

  // One-hot select makes an AND-OR mux sufficient.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_GROUPS; k++) begin
      if (sel_q[k]) rd_mux = rd_mux | spr_dat_o[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    hit_d   = hit_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (s.cyc && s.stb) begin
          adr_d   = s.adr;
          dat_d   = s.dat_w;
          we_d    = s.we;
          hit_d   = dec_hit;
          sel_d   = dec_sel;
          rdata_d = '0;
          state_d = dec_hit ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        // Writes return zero on DAT_R, so only reads capture channel data.
        rdata_d = we_q ? '0 : rd_mux;
        if (HAS_WAIT) begin
          cnt_d   = WAIT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!s.cyc) begin
          // Master gave up; the SPR side effect has already happened.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from registered state only, so reset clears them at once.
  assign spr_cs    = (state_q == ST_ACCESS) ? sel_q : '0;
  assign spr_write = (state_q == ST_ACCESS) && we_q;
  assign spr_addr  = adr_q;
  assign spr_dat_i = dat_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  assign s.ack   = (state_q == ST_RESP) && (hit_q || !ERR_EN);
  assign s.err   = (state_q == ST_RESP) && !hit_q && ERR_EN;
  assign s.dat_r = (state_q == ST_RESP) ? rdata_q : '0;

endmodule
